bus_drvr_fifo_if: RTL and testbench

BUS_DRVR_FIFO_IF -- requirements
Module: bus_drvr_fifo_if

---
 rtl/bus_drvr_fifo_if.sv | 118 +++++++++++
 tb/tb_bus_drvr_fifo_if.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_drvr_fifo_if.sv
// Bus driver FIFO interface: a TX FIFO carries words from the PE onto the bus,
// and an RX FIFO carries words from the bus to the PE. The two FIFOs are
// independent circular buffers. Both head words are first-word-fall-through.
//
// Handshake semantics:
//   TX write  : accepted when pe_wr_en && (!pe_wr_full || pop).
//   TX pop    : accepted when pop && pndng.
//   RX push   : accepted when push && (!full || pe_rd_en && pe_rd_valid).
//               The bus has no back-pressure, so a push that is refused is
//               dropped and sets rx_overflow.
//   RX read   : accepted when pe_rd_en && pe_rd_valid.
// Every status output is derived from registers only, so no input has a
// combinational path to any output.
module bus_drvr_fifo_if #(
  parameter int bits  = 32,
  parameter int depth = 16,
  parameter int cw    = $clog2(depth) + 1
) (
  input  logic            clk,
  input  logic            reset,
  // PE side of TX
  input  logic            pe_wr_en,
  input  logic [bits-1:0] pe_wr_data,
  output logic            pe_wr_full,
  // Bus side of TX
  output logic            pndng,
  output logic [bits-1:0] D_pop,
  input  logic            pop,
  // Bus side of RX
  input  logic            push,
  input  logic [bits-1:0] D_push,
  // PE side of RX
  input  logic            pe_rd_en,
  output logic [bits-1:0] pe_rd_data,
  output logic            pe_rd_valid,
  // Status
  output logic            rx_overflow,
  output logic            tx_underrun,
  output logic [cw-1:0]   tx_count,
  output logic [cw-1:0]   rx_count
);

  localparam int aw = $clog2(depth);
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [bits-1:0] tx_mem [depth];
  logic [bits-1:0] rx_mem [depth];

  logic [aw-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [aw-1:0] rx_wr_ptr, rx_rd_ptr;

  logic tx_wr_acc, tx_pop_acc;
  logic rx_push_acc, rx_rd_acc;
  logic rx_full;

  // Status flags come straight from the occupancy counters.
  assign pe_wr_full  = (tx_count == full_cnt);
  assign pndng       = (tx_count != '0);
  assign rx_full     = (rx_count == full_cnt);
  assign pe_rd_valid = (rx_count != '0);

  // Head words are read from storage at the read pointer. They are
  // undefined while the FIFO is empty.
  assign D_pop      = tx_mem[tx_rd_ptr];
  assign pe_rd_data = rx_mem[rx_rd_ptr];

  // Acceptance terms. A pop or read on a full FIFO frees the slot being
  // written in the same cycle, so the write or push may proceed.
  assign tx_pop_acc  = pop && pndng;
  assign tx_wr_acc   = pe_wr_en && (!pe_wr_full || pop);
  assign rx_rd_acc   = pe_rd_en && pe_rd_valid;
  assign rx_push_acc = push && (!rx_full || rx_rd_acc);

  // TX storage write. The storage is not reset; only the pointers define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && tx_wr_acc) tx_mem[tx_wr_ptr] <= pe_wr_data;
  end

  // RX storage write. The storage is not reset.
  always_ff @(posedge clk) begin
    if (!reset && rx_push_acc) rx_mem[rx_wr_ptr] <= D_push;
  end

  // TX pointers, occupancy and the sticky underrun flag.
  // The pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      if (tx_wr_acc)  tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop_acc) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_wr_acc && !tx_pop_acc)      tx_count <= tx_count + 1'b1;
      else if (!tx_wr_acc && tx_pop_acc) tx_count <= tx_count - 1'b1;
      if (pop && !pndng) tx_underrun <= 1'b1;
    end
  end

  // RX pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push_acc) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_rd_acc)   rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push_acc && !rx_rd_acc)      rx_count <= rx_count + 1'b1;
      else if (!rx_push_acc && rx_rd_acc) rx_count <= rx_count - 1'b1;
      if (push && !rx_push_acc) rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_drvr_fifo_if.sv
// Directed testbench for bus_drvr_fifo_if with the default parameters
// (32-bit words, depth 16). Inputs change 1 ns after a rising edge, and
// outputs are sampled at that same point.
module tb_bus_drvr_fifo_if;

  localparam int bits  = 32;
  localparam int depth = 16;
  localparam int cw    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            pe_wr_en;
  logic [bits-1:0] pe_wr_data;
  logic            pe_wr_full;
  logic            pndng;
  logic [bits-1:0] D_pop;
  logic            pop;
  logic            push;
  logic [bits-1:0] D_push;
  logic            pe_rd_en;
  logic [bits-1:0] pe_rd_data;
  logic            pe_rd_valid;
  logic            rx_overflow;
  logic            tx_underrun;
  logic [cw-1:0]   tx_count;
  logic [cw-1:0]   rx_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected-data queue for the scoreboard.
  logic [bits-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bus_drvr_fifo_if #(.bits(bits), .depth(depth), .cw(cw)) dut (
    .clk(clk), .reset(reset),
    .pe_wr_en(pe_wr_en), .pe_wr_data(pe_wr_data), .pe_wr_full(pe_wr_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .pe_rd_en(pe_rd_en), .pe_rd_data(pe_rd_data), .pe_rd_valid(pe_rd_valid),
    .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pe_wr_en = 1'b0;
    pop      = 1'b0;
    push     = 1'b0;
    pe_rd_en = 1'b0;
  endtask

  task automatic tx_write(input logic [bits-1:0] d);
    pe_wr_en   = 1'b1;
    pe_wr_data = d;
    step();
    idle();
  endtask

  task automatic rx_push(input logic [bits-1:0] d);
    push   = 1'b1;
    D_push = d;
    step();
    idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    pe_wr_data = '0;
    D_push     = '0;
    step();
    step();
    reset = 1'b0;
    n_tests++;
    if (tx_count !== 0 || rx_count !== 0) begin
      n_fail++;
      $display("FAIL reset_counts: tx_count=%0d rx_count=%0d expected 0/0", tx_count, rx_count);
    end
    n_tests++;
    if ({pndng, pe_rd_valid, pe_wr_full} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: pndng/valid/full=%b expected 000", {pndng, pe_rd_valid, pe_wr_full});
    end
    n_tests++;
    if ({rx_overflow, tx_underrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: ovf/unr=%b expected 00", {rx_overflow, tx_underrun});
    end
  endtask

  task automatic test_single_word();
    pe_wr_en   = 1'b1;
    pe_wr_data = 32'hA5A5_0001;
    // The write has not reached an edge yet, so pndng must still be low.
    n_tests++;
    if (pndng !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_bypass: pndng=%b expected 0", pndng);
    end
    step();
    idle();
    n_tests++;
    if (pndng !== 1'b1 || tx_count !== 1) begin
      n_fail++;
      $display("FAIL single_written: pndng=%b tx_count=%0d expected 1/1", pndng, tx_count);
    end
    n_tests++;
    if (D_pop !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_data: D_pop=%h expected a5a50001", D_pop);
    end
    pop = 1'b1;
    step();
    idle();
    n_tests++;
    if (pndng !== 1'b0 || tx_count !== 0) begin
      n_fail++;
      $display("FAIL single_popped: pndng=%b tx_count=%0d expected 0/0", pndng, tx_count);
    end
  endtask

  task automatic test_tx_fill();
    // The read pointer sits at 1 now, so this fill wraps the pointers.
    for (int i = 0; i < depth; i++) tx_write(32'(i));
    n_tests++;
    if (pe_wr_full !== 1'b1 || tx_count !== 16) begin
      n_fail++;
      $display("FAIL fill_full: full=%b tx_count=%0d expected 1/16", pe_wr_full, tx_count);
    end
    tx_write(32'hDEAD);
    n_tests++;
    if (tx_count !== 16 || D_pop !== 32'd0) begin
      n_fail++;
      $display("FAIL fill_drop: tx_count=%0d D_pop=%h expected 16/0", tx_count, D_pop);
    end
    for (int i = 0; i < depth; i++) begin
      n_tests++;
      if (D_pop !== 32'(i)) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: D_pop=%h expected %h", i, D_pop, 32'(i));
      end
      pop = 1'b1;
      step();
      idle();
    end
    n_tests++;
    if (tx_count !== 0 || pndng !== 1'b0 || tx_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drained: tx_count=%0d pndng=%b unr=%b expected 0/0/0", tx_count, pndng, tx_underrun);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tx_write(32'h300 + 32'(i));
      exp_q.push_back(32'h300 + 32'(i));
    end
    // A write and a pop in the same cycle keep the occupancy constant.
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (D_pop !== exp_q[0]) begin
        n_fail++;
        $display("FAIL b2b_head[%0d]: D_pop=%h expected %h", i, D_pop, exp_q[0]);
      end
      pe_wr_en   = 1'b1;
      pe_wr_data = 32'h310 + 32'(i);
      pop        = 1'b1;
      step();
      idle();
      void'(exp_q.pop_front());
      exp_q.push_back(32'h310 + 32'(i));
      n_tests++;
      if (tx_count !== 3) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: tx_count=%0d expected 3", i, tx_count);
      end
    end
    while (exp_q.size() != 0) begin
      n_tests++;
      if (D_pop !== exp_q[0]) begin
        n_fail++;
        $display("FAIL b2b_drain: D_pop=%h expected %h", D_pop, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pop = 1'b1;
      step();
      idle();
    end
  endtask

  task automatic test_tx_full_wr_pop();
    exp_q.delete();
    for (int i = 0; i < depth; i++) begin
      tx_write(32'h100 + 32'(i));
      exp_q.push_back(32'h100 + 32'(i));
    end
    pe_wr_en   = 1'b1;
    pe_wr_data = 32'h99;
    pop        = 1'b1;
    step();
    idle();
    void'(exp_q.pop_front());
    exp_q.push_back(32'h99);
    n_tests++;
    if (tx_count !== 16 || pe_wr_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_wrpop_count: tx_count=%0d full=%b expected 16/1", tx_count, pe_wr_full);
    end
    for (int i = 0; i < depth; i++) begin
      n_tests++;
      if (D_pop !== exp_q[0]) begin
        n_fail++;
        $display("FAIL full_wrpop_order[%0d]: D_pop=%h expected %h", i, D_pop, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pop = 1'b1;
      step();
      idle();
    end
    n_tests++;
    if (tx_count !== 0) begin
      n_fail++;
      $display("FAIL full_wrpop_drained: tx_count=%0d expected 0", tx_count);
    end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < depth; i++) rx_push(32'h200 + 32'(i));
    n_tests++;
    if (rx_count !== 16 || rx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_fill: rx_count=%0d ovf=%b expected 16/0", rx_count, rx_overflow);
    end
    rx_push(32'h2FF);
    n_tests++;
    if (rx_count !== 16 || rx_overflow !== 1'b1 || pe_rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_overflow: rx_count=%0d ovf=%b valid=%b expected 16/1/1", rx_count, rx_overflow, pe_rd_valid);
    end
    for (int i = 0; i < depth; i++) begin
      n_tests++;
      if (pe_rd_data !== 32'h200 + 32'(i)) begin
        n_fail++;
        $display("FAIL rx_order[%0d]: pe_rd_data=%h expected %h", i, pe_rd_data, 32'h200 + 32'(i));
      end
      pe_rd_en = 1'b1;
      step();
      idle();
    end
    n_tests++;
    if (rx_count !== 0 || pe_rd_valid !== 1'b0 || rx_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_drained: rx_count=%0d valid=%b ovf=%b expected 0/0/1", rx_count, pe_rd_valid, rx_overflow);
    end
    // A read while empty is ignored.
    pe_rd_en = 1'b1;
    step();
    idle();
    n_tests++;
    if (rx_count !== 0 || pe_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_empty_read: rx_count=%0d valid=%b expected 0/0", rx_count, pe_rd_valid);
    end
  endtask

  task automatic test_underrun();
    pop = 1'b1;
    step();
    idle();
    n_tests++;
    if (tx_underrun !== 1'b1 || tx_count !== 0 || pndng !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun: unr=%b tx_count=%0d pndng=%b expected 1/0/0", tx_underrun, tx_count, pndng);
    end
    // The pointers must not have moved: the next write lands at the head.
    tx_write(32'h77);
    n_tests++;
    if (D_pop !== 32'h77 || tx_count !== 1 || tx_underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_ptr: D_pop=%h tx_count=%0d unr=%b expected 77/1/1", D_pop, tx_count, tx_underrun);
    end
    pop = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tx_write(32'h400 + 32'(i));
    for (int i = 0; i < 3; i++) rx_push(32'h500 + 32'(i));
    n_tests++;
    if (tx_count !== 5 || rx_count !== 3) begin
      n_fail++;
      $display("FAIL pre_reset: tx_count=%0d rx_count=%0d expected 5/3", tx_count, rx_count);
    end
    reset      = 1'b1;
    pe_wr_en   = 1'b1;
    pe_wr_data = 32'h4FF;
    push       = 1'b1;
    D_push     = 32'h5FF;
    step();
    reset = 1'b0;
    idle();
    n_tests++;
    if (tx_count !== 0 || rx_count !== 0 || pndng !== 1'b0 || pe_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: tx=%0d rx=%0d pndng=%b valid=%b expected 0/0/0/0", tx_count, rx_count, pndng, pe_rd_valid);
    end
    n_tests++;
    if ({rx_overflow, tx_underrun, pe_wr_full} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_flags: ovf/unr/full=%b expected 000", {rx_overflow, tx_underrun, pe_wr_full});
    end
  endtask

  task automatic test_rx_full_push_read();
    exp_q.delete();
    for (int i = 0; i < depth; i++) begin
      rx_push(32'h600 + 32'(i));
      exp_q.push_back(32'h600 + 32'(i));
    end
    // A read on a full RX FIFO makes room for a same-cycle push.
    push     = 1'b1;
    D_push   = 32'h6AA;
    pe_rd_en = 1'b1;
    step();
    idle();
    void'(exp_q.pop_front());
    exp_q.push_back(32'h6AA);
    n_tests++;
    if (rx_count !== 16 || rx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_push_read: rx_count=%0d ovf=%b expected 16/0", rx_count, rx_overflow);
    end
    for (int i = 0; i < depth; i++) begin
      n_tests++;
      if (pe_rd_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL rx_push_read_order[%0d]: pe_rd_data=%h expected %h", i, pe_rd_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pe_rd_en = 1'b1;
      step();
      idle();
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_tx_fill();
    test_back_to_back();
    test_tx_full_wr_pop();
    test_rx_overflow();
    test_underrun();
    test_reset_mid();
    test_rx_full_push_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
